// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch stage: the buffered fetch entry
// and the post-reset fetch address.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a combinational head; flush empties it
// and wins over a same-cycle push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: sequential PC generation, credit-limited in-order instruction memory
// requests, buffering of returned words and redirect handling with stale-response drops.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready
);

    logic [31:0]      pc;
    logic [31:0]      rsp_pc;
    logic [31:0]      redirect_target;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   in_use;
    logic             fifo_full;
    logic             fifo_empty;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_keep;
    logic             pop;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    assign redirect_target = word_align(redirect_pc);

    // Every request reserves a FIFO slot, so responses never need backpressure.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok = !fifo_full && (in_use < (CNT_W + 1)'(FIFO_DEPTH));

    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep   = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

    assign o_valid       = !reset && !fifo_empty;
    assign o_instruction = o_valid ? head.instr : '0;
    assign o_pc          = o_valid ? head.pc : '0;
    assign pop           = o_valid && i_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (rsp_keep),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Responses still in flight at a redirect belong to the old path and are
    // counted into drop_cnt; the one arriving in the redirect cycle is already gone.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                pc       <= redirect_target;
                rsp_pc   <= redirect_target;
                drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rsp_valid) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - CNT_W'(1);
                    end else begin
                        rsp_pc <= rsp_pc + 32'd4;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: an epoch-tagged memory model feeds responses,
// and expected decoder words are queued and checked by an independent monitor.
module tb_fetch_stage;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        i_ready;

    fetch_stage #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .o_instruction  (o_instruction),
        .o_pc           (o_pc),
        .o_valid        (o_valid),
        .i_ready        (i_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mem_req_t    pending[$];
    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          epoch = 0;
    int unsigned ready_pct = 100;
    int unsigned iready_pct = 100;
    int unsigned rsp_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic [31:0] exp_addr = RST_PC;
    int          first_req_cyc = -1;
    int          first_valid_cyc = -1;
    int          req_count = 0;
    logic [31:0] first_pop_pc = 32'hDEAD_BEEF;
    logic [31:0] first_req_addr = 32'hDEAD_BEEF;
    bit          want_first_pop = 1'b0;
    bit          want_first_req = 1'b0;
    bit          redir_saw_rsp = 1'b0;
    bit          redir_saw_pop = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: memory model answers the oldest request once its latency elapsed.
    task automatic applyStimulus(input bit rst, input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        cyc++;
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        i_ready        = ($urandom_range(99) < iready_pct);
        if (!rst && pending.size() != 0 && pending[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pending[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: compares the DUT against the queued expectations, then updates the model.
    always @(negedge clk) begin : monitor
        bit       exp_rv;
        mem_req_t m;
        #2;
        if (reset) begin
            checkOutput("reset_req_valid", 32'(imem_req_valid), 32'd0);
            checkOutput("reset_o_valid", 32'(o_valid), 32'd0);
            checkOutput("reset_o_pc", o_pc, 32'd0);
            checkOutput("reset_o_instruction", o_instruction, 32'd0);
            pending.delete();
            exp_q.delete();
            exp_addr = RST_PC;
            epoch++;
            want_first_req = 1'b1;
        end else begin
            exp_rv = !redirect_valid && (pending.size() + exp_q.size() < DEPTH);
            checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            checkOutput("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
            if (redirect_valid) begin
                redir_saw_rsp = imem_rsp_valid;
                redir_saw_pop = o_valid && i_ready;
            end
            if (o_valid && exp_q.size() != 0) begin
                checkOutput("o_pc", o_pc, exp_q[0].pc);
                checkOutput("o_instruction", o_instruction, exp_q[0].instr);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (i_ready) begin
                    if (want_first_pop) begin
                        first_pop_pc   = o_pc;
                        want_first_pop = 1'b0;
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (imem_rsp_valid && pending.size() != 0) begin
                m = pending.pop_front();
                if (!redirect_valid && m.epoch == epoch) begin
                    exp_q.push_back('{pc: m.addr, instr: mem_word(m.addr)});
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                checkOutput("req_addr", imem_req_addr, exp_addr);
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (want_first_req) begin
                    first_req_addr = imem_req_addr;
                    want_first_req = 1'b0;
                end
                pending.push_back('{addr: imem_req_addr,
                                    due: cyc + int'($urandom_range(lat_max, lat_min)),
                                    epoch: epoch});
                exp_addr += 32'd4;
                req_count++;
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_addr       = redirect_pc & ~32'h3;
                epoch++;
                want_first_pop = 1'b1;
                want_first_req = 1'b1;
            end
        end
    end

    initial begin
        int unsigned r;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        i_ready        = 1'b0;

        // Back-to-back fetch with single-cycle memory and an always-ready decoder.
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
        first_req_cyc   = -1;
        first_valid_cyc = -1;
        runCycles(12);
        checkOutput("first_valid_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);

        // Decoder stalled: only DEPTH requests may be accepted, then drain.
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
        req_count  = 0;
        iready_pct = 0;
        runCycles(10);
        checkOutput("requests_while_stalled", 32'(req_count), 32'(DEPTH));
        iready_pct = 100;
        runCycles(10);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat_min = 3;
        lat_max = 3;
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
        runCycles(2);
        first_pop_pc   = 32'hDEAD_BEEF;
        first_req_addr = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b1, 32'h0000_0103);
        runCycles(14);
        checkOutput("redirect_req_addr", first_req_addr, 32'h0000_0100);
        checkOutput("redirect_first_pc", first_pop_pc, 32'h0000_0100);

        // Redirect coinciding with a memory response and a decoder pop.
        lat_min = 2;
        lat_max = 2;
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
        runCycles(8);
        redir_saw_rsp = 1'b0;
        redir_saw_pop = 1'b0;
        first_pop_pc  = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b1, 32'h0000_2000);
        runCycles(10);
        checkOutput("rsp_in_redirect_cycle", 32'(redir_saw_rsp), 32'd1);
        checkOutput("pop_in_redirect_cycle", 32'(redir_saw_pop), 32'd1);
        checkOutput("redirect2_first_pc", first_pop_pc, 32'h0000_2000);

        // PC wraps from the top of the address space.
        lat_min      = 1;
        lat_max      = 1;
        first_pop_pc = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        runCycles(10);
        checkOutput("wrap_first_pc", first_pop_pc, 32'hFFFF_FFFC);

        // Reset while the buffer holds words and requests are in flight.
        lat_min    = 3;
        lat_max    = 3;
        iready_pct = 0;
        runCycles(6);
        first_req_addr = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 1'b0, 32'h0);
        iready_pct = 100;
        runCycles(4);
        checkOutput("post_reset_req_addr", first_req_addr, RST_PC);

        // Random soak with occasional redirects and resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                ready_pct  = $urandom_range(100, 20);
                iready_pct = $urandom_range(100, 20);
                rsp_pct    = $urandom_range(100, 30);
                lat_min    = 1;
                lat_max    = $urandom_range(5, 1);
            end
            r = $urandom_range(999);
            if (r < 5) begin
                applyStimulus(1'b1, 1'b0, 32'h0);
            end else if (r < 15) begin
                applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF0 | 32'($urandom_range(15)));
            end else if (r < 35) begin
                applyStimulus(1'b0, 1'b1, $urandom);
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0);
            end
        end
        ready_pct  = 100;
        iready_pct = 100;
        rsp_pct    = 100;
        runCycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
